fifo_sync_pkt: RTL
==================

FIFO_SYNC_PKT -- requirements
Module: fifo_sync_pkt

Interface
REQ-001 SHALL have parameter pDATA_WIDTH, default 16, word width in bits (1..256).
REQ-002 SHALL have parameter pDEPTH, default 512, capacity in words; power of two, >= 4.
REQ-003 SHALL have parameter pFALLTHROUGH, default 0, selecting first-word-fall-through read mode when 1.
REQ-004 SHALL have ports clk in 1, the single clock; rst in 1, asynchronous active-high reset.
REQ-005 SHALL have ports full_threshold_value in 32 and empty_threshold_value in 32, the programmable level thresholds.
REQ-006 SHALL have ports wen in 1 (write strobe) and wdata in pDATA_WIDTH (write word).
REQ-007 SHALL have ports wcommit in 1 (publish pending words) and wdiscard in 1 (roll back pending words).
REQ-008 SHALL have ports ren in 1 (read strobe) and rdata out pDATA_WIDTH (read word).
REQ-009 SHALL have status outputs full, almost_full, full_threshold, overflow, empty, almost_empty, empty_threshold and underflow, each 1 bit.
REQ-010 SHALL have outputs wr_level and rd_level, each LW = clog2(pDEPTH)+1 bits, giving the occupied word count and the committed word count.

Function
REQ-011 SHALL keep three LW-bit pointers (wptr write, cptr commit, rptr read), each wrapping modulo 2*pDEPTH.
REQ-012 SHALL store wdata at wptr and increment wptr when wen=1 and full=0.
REQ-013 SHALL set cptr to the post-write wptr on wcommit=1, so a word written in the same cycle is included.
REQ-014 SHALL set wptr to cptr on wdiscard=1, so a word written in the same cycle is also dropped.
REQ-015 SHALL give wcommit priority when wcommit and wdiscard are both 1 in one cycle, and ignore wdiscard.
REQ-016 SHALL compute wr_level = wptr-rptr and rd_level = cptr-rptr, both registered and updated the cycle after the causing event.
REQ-017 SHALL assert full when wr_level == pDEPTH, so uncommitted words consume capacity.
REQ-018 SHALL assert empty when rd_level == 0, so uncommitted words are invisible to the reader.
REQ-019 SHALL assert almost_full when wr_level >= pDEPTH-1 and almost_empty when rd_level <= 1.
REQ-020 SHALL assert full_threshold when wr_level >= full_threshold_value and empty_threshold when rd_level <= empty_threshold_value.
REQ-021 SHALL, when pFALLTHROUGH=0, on ren=1 with empty=0, register the word at rptr onto rdata one cycle later, increment rptr, and otherwise hold rdata.
REQ-022 SHALL, when pFALLTHROUGH=1, present the word at rptr on rdata whenever empty=0, with ren=1 popping it.
REQ-023 SHALL pulse overflow for one cycle, the cycle after any wen=1 while full=1; the word is dropped and no state changes.
REQ-024 SHALL pulse underflow for one cycle, the cycle after any ren=1 while empty=1; rptr and rdata are unchanged.
REQ-025 SHALL accept a simultaneous read and write when full=1 and committed data exists: the read frees a slot next cycle and the write is dropped with overflow.
REQ-026 SHALL make a committed word readable with empty deasserted at most one cycle after the commit edge.

Reset
REQ-027 SHALL, on rst=1, immediately clear all pointers, wr_level, rd_level, rdata, overflow, underflow, full, almost_full and full_threshold, and set empty=1 and almost_empty=1.
REQ-028 SHALL set empty_threshold=1 during reset when empty_threshold_value >= 0.
REQ-029 SHALL, on reset asserted mid-packet, discard all pending and committed data; storage contents are not cleared.

Structure
REQ-030 SHALL take the LW level-width function and the pointer-difference helper from the shared fifo_pkg package.
REQ-031 SHALL implement storage as one sub-module, fifo_mem (pDEPTH x pDATA_WIDTH flop array, one write port, one async read port).

Verification
REQ-032 SHALL cover: 3 writes (0x0001..0x0003), no commit -> empty=1, wr_level=3, rd_level=0; then wcommit -> rd_level=3 next cycle.
REQ-033 SHALL cover: commit 2 words, write 4 more, wdiscard -> wr_level=2; reads return 0x0001, 0x0002, then underflow on the third ren.
REQ-034 SHALL cover, with pDEPTH=512: 512 writes plus commit -> full=1; a 513th wen -> overflow pulse, wr_level=512.
REQ-035 SHALL cover: wen, wcommit and wdiscard asserted together -> the word is committed, rd_level +1.
REQ-036 SHALL cover, with full_threshold_value=10 and empty_threshold_value=2: 10 writes -> full_threshold=1; reading down to 2 -> empty_threshold=1.
REQ-037 SHALL cover: rst pulsed mid-packet after 5 pending words -> all levels 0 and empty=1 immediately; both pFALLTHROUGH values are exercised.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: level width, wrapping-pointer occupancy and the
// write-side pointer action decoded from the commit/discard strobes.
package fifo_pkg;

  typedef enum logic [1:0] {
    WR_HOLD    = 2'd0,
    WR_COMMIT  = 2'd1,
    WR_DISCARD = 2'd2
  } wr_action_e;

  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Pointers carry one extra wrap bit, so the masked difference tells full from empty.
  function automatic logic [31:0] ptr_diff(input logic [31:0] head,
                                           input logic [31:0] tail,
                                           input int          lw);
    logic [31:0] mask;
    mask = (lw >= 32) ? '1 : ((32'd1 << lw) - 32'd1);
    return (head - tail) & mask;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: flop array with one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module fifo_mem #(
  parameter  int pDATA_WIDTH = 16,
  parameter  int pDEPTH      = 512,
  localparam int AW          = $clog2(pDEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]          raddr,
  output logic [pDATA_WIDTH-1:0] rdata
);

  logic [pDATA_WIDTH-1:0] mem [pDEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_pkt.sv
// Single-clock packet FIFO: writes stay pending (invisible to the reader)
// until committed, and pending words can be rolled back as a group.
module fifo_sync_pkt
  import fifo_pkg::*;
#(
  parameter  int pDATA_WIDTH  = 16,
  parameter  int pDEPTH       = 512,
  parameter  int pFALLTHROUGH = 0,
  localparam int LW           = level_width(pDEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            full_threshold_value,
  input  logic [31:0]            empty_threshold_value,
  input  logic                   wen,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   wcommit,
  input  logic                   wdiscard,
  input  logic                   ren,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic                   full,
  output logic                   almost_full,
  output logic                   full_threshold,
  output logic                   overflow,
  output logic                   empty,
  output logic                   almost_empty,
  output logic                   empty_threshold,
  output logic                   underflow,
  output logic [LW-1:0]          wr_level,
  output logic [LW-1:0]          rd_level
);

  localparam int            AW       = LW - 1;
  localparam logic [LW-1:0] DEPTH_L  = LW'(pDEPTH);
  localparam logic [LW-1:0] DEPTH_M1 = LW'(pDEPTH - 1);

  logic [LW-1:0]          wptr, cptr, rptr;
  logic [LW-1:0]          wptr_p0, wptr_nxt, cptr_nxt, rptr_nxt;
  logic                   wr_ok, rd_ok;
  wr_action_e             wr_action;
  logic [pDATA_WIDTH-1:0] mem_rdata;

  assign wr_ok     = wen & ~full;
  assign rd_ok     = ren & ~empty;
  assign wptr_p0   = wptr + LW'(wr_ok);
  assign rptr_nxt  = rptr + LW'(rd_ok);
  assign wr_action = wcommit ? WR_COMMIT : (wdiscard ? WR_DISCARD : WR_HOLD);

  // Commit publishes the post-write pointer; discard rewinds past this cycle's write too.
  always_comb begin
    wptr_nxt = wptr_p0;
    cptr_nxt = cptr;
    case (wr_action)
      WR_COMMIT:  cptr_nxt = wptr_p0;
      WR_DISCARD: wptr_nxt = cptr;
      default:    ;
    endcase
  end

  // Pointer and level registers; levels are taken from next-state pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      cptr      <= '0;
      rptr      <= '0;
      wr_level  <= '0;
      rd_level  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wptr      <= wptr_nxt;
      cptr      <= cptr_nxt;
      rptr      <= rptr_nxt;
      wr_level  <= LW'(ptr_diff(32'(wptr_nxt), 32'(rptr_nxt), LW));
      rd_level  <= LW'(ptr_diff(32'(cptr_nxt), 32'(rptr_nxt), LW));
      overflow  <= wen & full;
      underflow <= ren & empty;
    end
  end

  assign full            = (wr_level == DEPTH_L);
  assign almost_full     = (wr_level >= DEPTH_M1);
  assign full_threshold  = (32'(wr_level) >= full_threshold_value);
  assign empty           = (rd_level == '0);
  assign almost_empty    = (rd_level <= LW'(1));
  assign empty_threshold = (32'(rd_level) <= empty_threshold_value);

  fifo_mem #(
    .pDATA_WIDTH (pDATA_WIDTH),
    .pDEPTH      (pDEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wptr[AW-1:0]),
    .wdata (wdata),
    .raddr (rptr[AW-1:0]),
    .rdata (mem_rdata)
  );

  // Read stage: registered word in standard mode, head word shown directly in FWFT mode
  generate
    if (pFALLTHROUGH != 0) begin : g_fwft
      assign rdata = empty ? '0 : mem_rdata;
    end else begin : g_std
      always_ff @(posedge clk or posedge rst) begin
        if (rst)        rdata <= '0;
        else if (rd_ok) rdata <= mem_rdata;
      end
    end
  endgenerate

endmodule
